// File: rtl/mem_port_arbiter_if.sv
// SRAM-like req/addr_ok/data_ok bus. The master issues requests and the slave answers them.
interface mem_port_arbiter_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store.
// Responses return in order, so a small FIFO of owner bits steers each data_ok
// back to the requester that issued it.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUT = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  inst,
    mem_port_arbiter_if.slave  data,
    mem_port_arbiter_if.master mem,
    output logic               proto_err
);

    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

    typedef enum logic {
        OwnInst = 1'b0,
        OwnData = 1'b1
    } owner_e;

    owner_e             owner_q [MAX_OUT];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               hold_q, hold_d;
    owner_e             hold_owner_q, hold_owner_d;
    owner_e             last_q, last_d;
    logic               proto_err_q, proto_err_d;

    owner_e             grant;
    owner_e             head;
    logic               grant_req;
    logic               not_full;
    logic               fifo_valid;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Grant: a stalled request keeps the port; otherwise alternate under contention.
    always_comb begin
        if (hold_q) begin
            grant = hold_owner_q;
        end else if (inst.req && data.req) begin
            grant = (last_q == OwnInst) ? OwnData : OwnInst;
        end else if (data.req) begin
            grant = OwnData;
        end else begin
            grant = OwnInst;
        end
    end

    // Payload mux from the granted requester onto the memory port.
    always_comb begin
        if (grant == OwnData) begin
            grant_req = data.req;
            mem.wr    = data.wr;
            mem.wstrb = data.wstrb;
            mem.addr  = data.addr;
            mem.wdata = data.wdata;
        end else begin
            grant_req = inst.req;
            mem.wr    = inst.wr;
            mem.wstrb = inst.wstrb;
            mem.addr  = inst.addr;
            mem.wdata = inst.wdata;
        end
    end

    assign not_full   = (count_q < MAX_CNT);
    assign fifo_valid = (count_q != '0);
    assign head       = owner_q[rd_ptr_q];

    // Reset forces every handshake low combinationally.
    assign mem.req = grant_req & not_full & ~reset;
    assign push    = mem.req & mem.addr_ok;
    assign pop     = mem.data_ok & fifo_valid & ~reset;

    assign inst.addr_ok = push & (grant == OwnInst);
    assign data.addr_ok = push & (grant == OwnData);
    assign inst.data_ok = pop & (head == OwnInst);
    assign data.data_ok = pop & (head == OwnData);
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;
    assign proto_err    = proto_err_q;

    // Next-state for FIFO bookkeeping, grant history and the error flag.
    always_comb begin
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d      = count_q;
        hold_d       = hold_q;
        hold_owner_d = hold_owner_q;
        last_d       = push ? grant : last_q;
        proto_err_d  = proto_err_q | (mem.data_ok & ~fifo_valid);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // When full mem.req is 0, so hold is left untouched.
        if (mem.req && !mem.addr_ok) begin
            hold_d       = 1'b1;
            hold_owner_d = grant;
        end else if (push) begin
            hold_d = 1'b0;
        end
    end

    // State registers; reset discards any outstanding ownership.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            hold_q       <= 1'b0;
            hold_owner_q <= OwnInst;
            last_q       <= OwnInst;
            proto_err_q  <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= grant;
            end
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            hold_owner_q <= hold_owner_d;
            last_q       <= last_d;
            proto_err_q  <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: expected owners are queued at accept time and
// checked against the data_ok routing when the memory responds.
module tb_mem_port_arbiter;

    localparam int unsigned MAX_OUT = 2;

    logic clk;
    logic reset;
    logic proto_err;

    mem_port_arbiter_if inst_bus ();
    mem_port_arbiter_if data_bus ();
    mem_port_arbiter_if mem_bus ();

    mem_port_arbiter #(
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inst     (inst_bus),
        .data     (data_bus),
        .mem      (mem_bus),
        .proto_err(proto_err)
    );

    int checks;
    int errors;
    logic sb_owner[$];   // 0 = inst, 1 = data

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.wstrb = 4'h0;
        inst_bus.addr = 32'h0; inst_bus.wdata = 32'h0;
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.wstrb = 4'h0;
        data_bus.addr = 32'h0; data_bus.wdata = 32'h0;
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb_owner.delete();
    endtask

    // Drives a memory response in the current cycle and checks its routing.
    task automatic check_response(input logic [31:0] rd, input string name);
        logic own;
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = rd;
        #1;
        checks++;
        if (sb_owner.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty at response", name);
        end else begin
            own = sb_owner.pop_front();
            if (inst_bus.data_ok !== ~own) begin
                errors++;
                $display("FAIL %s inst_data_ok: got %b want %b", name, inst_bus.data_ok, ~own);
            end
            checks++;
            if (data_bus.data_ok !== own) begin
                errors++;
                $display("FAIL %s data_data_ok: got %b want %b", name, data_bus.data_ok, own);
            end
            checks++;
            if ((own ? data_bus.rdata : inst_bus.rdata) !== rd) begin
                errors++;
                $display("FAIL %s rdata: got %h want %h", name,
                         own ? data_bus.rdata : inst_bus.rdata, rd);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        inst_bus.req = 1'b1; data_bus.req = 1'b1;
        mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1;
        #1;
        checks++;
        if (mem_bus.req !== 1'b0) begin
            errors++; $display("FAIL reset_mem_req: got %b want 0", mem_bus.req);
        end
        checks++;
        if ({inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok} !== 4'b0) begin
            errors++;
            $display("FAIL reset_oks: got %b%b%b%b want 0000", inst_bus.addr_ok,
                     data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok);
        end
        @(negedge clk);
        set_idle();
        reset = 1'b0;
        #1;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err);
        end
        sb_owner.delete();
    endtask

    task automatic test_single_fetch();
        do_reset();
        // cycle 0: fetch accepted
        @(negedge clk);
        set_idle();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0000; mem_bus.addr_ok = 1'b1;
        #1;
        checks++;
        if (inst_bus.addr_ok !== 1'b1 || data_bus.addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_addr_ok: got inst=%b data=%b want inst=1 data=0",
                     inst_bus.addr_ok, data_bus.addr_ok);
        end
        checks++;
        if (mem_bus.addr !== 32'h1C00_0000 || mem_bus.wr !== 1'b0) begin
            errors++;
            $display("FAIL fetch_mem_addr: got %h wr=%b want 1c000000 wr=0", mem_bus.addr, mem_bus.wr);
        end
        sb_owner.push_back(1'b0);
        // cycle 1: waiting
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait_data_ok: got inst=%b data=%b want 0 0",
                     inst_bus.data_ok, data_bus.data_ok);
        end
        // cycle 2: response
        @(negedge clk);
        set_idle();
        check_response(32'h0280_0404, "fetch_rsp");
    endtask

    task automatic test_contention();
        do_reset();
        // cycle 0: data wins first after reset
        @(negedge clk);
        set_idle();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_1000;
        data_bus.req = 1'b1; data_bus.addr = 32'h0000_2000; data_bus.wr = 1'b1;
        data_bus.wstrb = 4'hF; data_bus.wdata = 32'hDEAD_BEEF;
        mem_bus.addr_ok = 1'b1;
        #1;
        checks++;
        if (data_bus.addr_ok !== 1'b1 || inst_bus.addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL contend_acc0: got data=%b inst=%b want data=1 inst=0",
                     data_bus.addr_ok, inst_bus.addr_ok);
        end
        checks++;
        if (mem_bus.addr !== 32'h0000_2000 || mem_bus.wr !== 1'b1 ||
            mem_bus.wstrb !== 4'hF || mem_bus.wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL contend_payload0: got addr=%h wr=%b wstrb=%h wdata=%h want 2000 1 f deadbeef",
                     mem_bus.addr, mem_bus.wr, mem_bus.wstrb, mem_bus.wdata);
        end
        sb_owner.push_back(1'b1);
        // cycle 1: inst next
        @(negedge clk);
        mem_bus.addr_ok = 1'b1;
        #1;
        checks++;
        if (inst_bus.addr_ok !== 1'b1 || data_bus.addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL contend_acc1: got inst=%b data=%b want inst=1 data=0",
                     inst_bus.addr_ok, data_bus.addr_ok);
        end
        checks++;
        if (mem_bus.addr !== 32'h0000_1000 || mem_bus.wr !== 1'b0) begin
            errors++;
            $display("FAIL contend_payload1: got addr=%h wr=%b want 1000 0", mem_bus.addr, mem_bus.wr);
        end
        sb_owner.push_back(1'b0);
        // cycle 2: full, no issue
        @(negedge clk);
        #1;
        checks++;
        if (mem_bus.req !== 1'b0 || inst_bus.addr_ok !== 1'b0 || data_bus.addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL contend_full: got mem_req=%b want 0", mem_bus.req);
        end
        // cycle 3: first response while still full
        @(negedge clk);
        check_response(32'h1111_1111, "contend_rsp0");
        checks++;
        if (mem_bus.req !== 1'b0) begin
            errors++; $display("FAIL contend_full_pop: got mem_req=%b want 0", mem_bus.req);
        end
        // cycle 4: second response
        @(negedge clk);
        set_idle();
        check_response(32'h2222_2222, "contend_rsp1");
    endtask

    task automatic test_hold();
        do_reset();
        // prime last=data with a lone data transaction
        @(negedge clk);
        set_idle();
        data_bus.req = 1'b1; data_bus.addr = 32'h0000_3000; mem_bus.addr_ok = 1'b1;
        #1;
        checks++;
        if (data_bus.addr_ok !== 1'b1) begin
            errors++; $display("FAIL hold_prime_acc: got %b want 1", data_bus.addr_ok);
        end
        sb_owner.push_back(1'b1);
        @(negedge clk);
        set_idle();
        check_response(32'h3333_3333, "hold_prime_rsp");
        // three stalled cycles: data alone first, then inst joins
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_idle();
            data_bus.req = 1'b1; data_bus.addr = 32'h0000_3004;
            if (c > 0) begin
                inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_1004;
            end
            #1;
            checks++;
            if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h0000_3004) begin
                errors++;
                $display("FAIL hold_stall%0d: got req=%b addr=%h want 1 00003004",
                         c, mem_bus.req, mem_bus.addr);
            end
        end
        // accept goes to the held data request
        @(negedge clk);
        mem_bus.addr_ok = 1'b1;
        #1;
        checks++;
        if (data_bus.addr_ok !== 1'b1 || inst_bus.addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL hold_acc: got data=%b inst=%b want data=1 inst=0",
                     data_bus.addr_ok, inst_bus.addr_ok);
        end
        sb_owner.push_back(1'b1);
        // next grant is inst
        @(negedge clk);
        data_bus.addr = 32'h0000_3008;
        mem_bus.addr_ok = 1'b1;
        #1;
        checks++;
        if (inst_bus.addr_ok !== 1'b1 || mem_bus.addr !== 32'h0000_1004) begin
            errors++;
            $display("FAIL hold_next_inst: got inst_addr_ok=%b addr=%h want 1 00001004",
                     inst_bus.addr_ok, mem_bus.addr);
        end
        sb_owner.push_back(1'b0);
        @(negedge clk);
        set_idle();
        check_response(32'h4444_4444, "hold_rsp0");
        @(negedge clk);
        set_idle();
        check_response(32'h5555_5555, "hold_rsp1");
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            set_idle();
            inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0000 + 32'(4 * c);
            mem_bus.addr_ok = 1'b1;
            #1;
            checks++;
            if (inst_bus.addr_ok !== 1'b1) begin
                errors++; $display("FAIL full_fill%0d: got %b want 1", c, inst_bus.addr_ok);
            end
            sb_owner.push_back(1'b0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_bus.req !== 1'b0 || inst_bus.addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL full_block: got req=%b addr_ok=%b want 0 0", mem_bus.req, inst_bus.addr_ok);
        end
        // pop cycle N: still blocked
        @(negedge clk);
        check_response(32'h6666_6666, "full_pop");
        checks++;
        if (mem_bus.req !== 1'b0) begin
            errors++; $display("FAIL full_pop_block: got %b want 0", mem_bus.req);
        end
        // cycle N+1: fresh accept
        @(negedge clk);
        mem_bus.data_ok = 1'b0;
        #1;
        checks++;
        if (mem_bus.req !== 1'b1 || inst_bus.addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL full_reissue: got req=%b addr_ok=%b want 1 1", mem_bus.req, inst_bus.addr_ok);
        end
        sb_owner.push_back(1'b0);
        // full again
        @(negedge clk);
        #1;
        checks++;
        if (mem_bus.req !== 1'b0) begin
            errors++; $display("FAIL full_refill: got %b want 0", mem_bus.req);
        end
        @(negedge clk);
        set_idle();
        check_response(32'h7777_7777, "full_rsp1");
        @(negedge clk);
        set_idle();
        check_response(32'h8888_8888, "full_rsp2");
    endtask

    task automatic test_push_pop();
        do_reset();
        @(negedge clk);
        set_idle();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_0040; mem_bus.addr_ok = 1'b1;
        #1;
        sb_owner.push_back(1'b0);
        // data accept and inst response together
        @(negedge clk);
        set_idle();
        data_bus.req = 1'b1; data_bus.addr = 32'h0000_0080; mem_bus.addr_ok = 1'b1;
        check_response(32'hAAAA_0001, "pp_rsp_inst");
        checks++;
        if (data_bus.addr_ok !== 1'b1) begin
            errors++; $display("FAIL pp_data_acc: got %b want 1", data_bus.addr_ok);
        end
        sb_owner.push_back(1'b1);
        // count should be 1: exactly one more accept fits
        @(negedge clk);
        set_idle();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_0044; mem_bus.addr_ok = 1'b1;
        #1;
        checks++;
        if (inst_bus.addr_ok !== 1'b1) begin
            errors++; $display("FAIL pp_count_one: got %b want 1", inst_bus.addr_ok);
        end
        sb_owner.push_back(1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (mem_bus.req !== 1'b0) begin
            errors++; $display("FAIL pp_count_full: got %b want 0", mem_bus.req);
        end
        @(negedge clk);
        set_idle();
        check_response(32'hBBBB_0002, "pp_rsp_data");
        @(negedge clk);
        set_idle();
        check_response(32'hCCCC_0003, "pp_rsp_inst2");
    endtask

    task automatic test_spurious();
        do_reset();
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++; $display("FAIL spur_pre: got %b want 0", proto_err);
        end
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = 32'hFFFF_0000;
        #1;
        checks++;
        if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0) begin
            errors++;
            $display("FAIL spur_data_ok: got inst=%b data=%b want 0 0",
                     inst_bus.data_ok, data_bus.data_ok);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_idle();
            #1;
            checks++;
            if (proto_err !== 1'b1) begin
                errors++; $display("FAIL spur_sticky%0d: got %b want 1", c, proto_err);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++; $display("FAIL spur_clear: got %b want 0", proto_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        set_idle();
        test_reset();
        test_single_fetch();
        test_contention();
        test_hold();
        test_full();
        test_push_pop();
        test_spurious();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
